regfile_wb_sequencer: RTL and testbench
=======================================

# regfile_wb_sequencer

Writeback controller for the SEQ register file. It accepts one retired instruction per handshake and computes the destination registers dstE and dstM from icode, rA, rB and cnd. It then drives the register file's single write port over one or two cycles, so popq's two writes are serialised through that one port. It sits between the execute/memory stages and the register-file write port, and exposes a ready signal that stalls upstream during multi-write sequences.

## Interface

Parameters:
- DATA_W, 64, register data width
- RNONE, 4'hF, "no register" encoding
- RSP, 4'd4, stack-pointer register index

Ports (name, direction, width, meaning). One clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  writeback request valid
- in_ready  out  1  controller can accept a request
- icode  in  4  instruction code
- rA  in  4  register specifier A
- rB  in  4  register specifier B
- cnd  in  1  condition result (used by cmovXX)
- valE  in  DATA_W  ALU result
- valM  in  DATA_W  memory read result
- wr_en  out  1  register-file write enable
- wr_addr  out  4  write address
- wr_data  out  DATA_W  write data
- wb_done  out  1  one-cycle pulse: request fully written back
- bad_icode  out  1  one-cycle pulse: icode > 4'hB accepted

## Operation

- Accept on a rising edge with in_valid && in_ready. At that edge, latch icode, rA, rB, cnd, valE and valM.
- dstE:
  - rB for icode 2 when cnd=1, for icode 3 and for icode 6.
  - RSP for icodes 8, 9, A and B.
  - Otherwise RNONE (including icode 2 when cnd=0).
- dstM: rA for icodes 5 and B; otherwise RNONE.
- Any write whose address is RNONE is suppressed.
- States:
  - IDLE: in_ready=1.
  - SECOND: in_ready=0; the M write is pending.
- Transitions:
  - IDLE→SECOND on accept only when both dstE and dstM are not RNONE (popq).
  - SECOND→IDLE unconditionally after one cycle.
  - All other accepts stay in IDLE.
- Write order when both writes are present: the E write (RSP←valE) comes first, then the M write (rA←valM). For popq %rsp the final RSP value is therefore valM.
- With only one valid destination, that single write is issued.
- With no valid destination (nop, halt, rmmovq, jXX, cmov with cnd=0, out-of-range rB), no write is issued and wb_done still pulses.
- icode > 4'hB: no write; bad_icode and wb_done pulse together.
- No arithmetic is performed; data passes through unmodified at DATA_W.

## Timing

- All outputs except in_ready are registered. in_ready = (state==IDLE) && !rst.
- Reset values: state IDLE, wr_en=0, wr_addr=RNONE, wr_data=0, wb_done=0, bad_icode=0.
- In the reset cycle in_ready=0 and no request is accepted.
- Accept at edge k:
  - The first (or only) write is visible during cycle k+1, and the register file commits it at edge k+1.
  - For a single-write or no-write request, wb_done=1 in cycle k+1.
  - For popq, the second write is visible in cycle k+2 with wb_done=1, and in_ready=0 throughout cycle k+1.
- Throughput: one request per cycle except popq, which takes two cycles.
- wr_en, wb_done and bad_icode are deasserted in every cycle with nothing to report.
- in_valid asserted while in_ready=0 is ignored; the source must hold the request until in_ready=1.
- If rst is asserted in cycle k+1 of a popq, the pending M write is dropped and all outputs return to reset values at that edge.
- Simultaneous accept and reset: reset wins and the request is not accepted.

## Test plan

- OPq: icode=6, rB=3, valE=0x25 → cycle k+1: wr_en=1, wr_addr=3, wr_data=0x25, wb_done=1; in_ready stays 1. A back-to-back irmovq (icode=3, rB=7, valE=9) is written at k+2.
- popq: icode=B, rA=2, valE=0x28, valM=0xDEAD → k+1: wr_addr=4, wr_data=0x28, in_ready=0; k+2: wr_addr=2, wr_data=0xDEAD, wb_done=1. A request held during k+1 is accepted at edge k+2.
- popq with rA=4, valE=0x30, valM=0x55 → writes 4←0x30 then 4←0x55, in that order.
- cmovXX: icode=2, rB=5, valE=7.
  - cnd=0 → wr_en=0 and wb_done=1.
  - cnd=1 → wr_addr=5, wr_data=7.
- rmmovq (icode=4) and nop (icode=1) → no write, wb_done=1. icode=C → bad_icode=1, wb_done=1, wr_en=0.
- Reset: rst=1 during k+1 of popq → no second write; outputs at reset values; in_ready=0 while rst=1 and 1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/regfile_wb_sequencer.sv
// Writeback controller for the SEQ register file: derives dstE/dstM from a retired
// instruction and serialises up to two writes through the single register-file write port.
module regfile_wb_sequencer #(
    parameter int          DATA_W = 64,
    parameter logic [3:0]  RNONE  = 4'hF,
    parameter logic [3:0]  RSP    = 4'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic              wr_en,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wb_done,
    output logic              bad_icode
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SECOND = 1'b1;

    logic [0:0]        state;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [3:0]        m_addr;
    logic [DATA_W-1:0] m_data;
    logic              accept;
    logic              bad;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign bad      = icode > 4'hB;

    always_comb begin
        dst_e = RNONE;
        case (icode)
            4'h2:                    if (cnd) dst_e = rB;
            4'h3, 4'h6:              dst_e = rB;
            4'h8, 4'h9, 4'hA, 4'hB:  dst_e = RSP;
            default:                 dst_e = RNONE;
        endcase
    end

    always_comb begin
        dst_m = RNONE;
        case (icode)
            4'h5, 4'hB: dst_m = rA;
            default:    dst_m = RNONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_en     <= 1'b0;
            wr_addr   <= RNONE;
            wr_data   <= '0;
            wb_done   <= 1'b0;
            bad_icode <= 1'b0;
            m_addr    <= RNONE;
            m_data    <= '0;
        end else begin
            wr_en     <= 1'b0;
            wr_addr   <= RNONE;
            wr_data   <= '0;
            wb_done   <= 1'b0;
            bad_icode <= 1'b0;
            if (state == SECOND) begin
                // Pending M write of popq; it lands after the RSP update so popq %rsp ends with valM.
                wr_en   <= 1'b1;
                wr_addr <= m_addr;
                wr_data <= m_data;
                wb_done <= 1'b1;
                state   <= IDLE;
            end else if (accept) begin
                if (bad) begin
                    wb_done   <= 1'b1;
                    bad_icode <= 1'b1;
                end else if (dst_e != RNONE && dst_m != RNONE) begin
                    wr_en   <= 1'b1;
                    wr_addr <= dst_e;
                    wr_data <= valE;
                    m_addr  <= dst_m;
                    m_data  <= valM;
                    state   <= SECOND;
                end else if (dst_e != RNONE) begin
                    wr_en   <= 1'b1;
                    wr_addr <= dst_e;
                    wr_data <= valE;
                    wb_done <= 1'b1;
                end else if (dst_m != RNONE) begin
                    wr_en   <= 1'b1;
                    wr_addr <= dst_m;
                    wr_data <= valM;
                    wb_done <= 1'b1;
                end else begin
                    wb_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: directed scenarios plus randomized traffic against a
// queue-based model of the expected write-port activity.
module tb_regfile_wb_sequencer;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    icode, rA, rB;
    logic          cnd;
    logic [DW-1:0] valE, valM;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          wb_done;
    logic          bad_icode;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          en;
        logic [3:0]    addr;
        logic [DW-1:0] data;
        logic          done;
        logic          bad;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_sequencer #(.DATA_W(DW), .RNONE(4'hF), .RSP(4'd4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wb_done(wb_done), .bad_icode(bad_icode)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [DW-1:0] e, input logic [DW-1:0] m);
        in_valid = 1'b1; icode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
    endtask

    // Reference: list of register writes an instruction performs, in port order.
    function automatic void model(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                                  input logic c, input logic [DW-1:0] e, input logic [DW-1:0] m);
        logic [3:0] de, dm;
        exp_t w[$];
        exp_t x;
        if (ic > 4'hB) begin
            x = '{en: 1'b0, addr: 4'hF, data: '0, done: 1'b1, bad: 1'b1};
            exp_q.push_back(x);
            return;
        end
        de = 4'hF; dm = 4'hF;
        if ((ic == 4'h2 && c) || ic == 4'h3 || ic == 4'h6) de = b;
        if (ic >= 4'h8) de = 4'd4;
        if (ic == 4'h5 || ic == 4'hB) dm = a;
        if (de != 4'hF) w.push_back('{en: 1'b1, addr: de, data: e, done: 1'b0, bad: 1'b0});
        if (dm != 4'hF) w.push_back('{en: 1'b1, addr: dm, data: m, done: 1'b0, bad: 1'b0});
        if (w.size() == 0) w.push_back('{en: 1'b0, addr: 4'hF, data: '0, done: 1'b0, bad: 1'b0});
        w[w.size()-1].done = 1'b1;
        foreach (w[i]) exp_q.push_back(w[i]);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        req(4'hB, 4'd2, 4'hF, 1'b0, 64'h11, 64'h22);
        tick(); tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, wb_done, bad_icode} !== {1'b0, 4'hF, 64'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h done=%b bad=%b required 0/f/0/0/0",
                     wr_en, wr_addr, wr_data, wb_done, bad_icode);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset: got %b required 1", in_ready);
        end
        tick();
        checks++;
        if ({wr_en, wb_done, bad_icode} !== 3'b000) begin
            failures++; $display("FAIL reset_no_accept: got en=%b done=%b bad=%b required 000", wr_en, wb_done, bad_icode);
        end
    endtask

    task automatic test_opq_back_to_back();
        req(4'h6, 4'hF, 4'd3, 1'b0, 64'h25, 64'h0);
        tick();
        req(4'h3, 4'hF, 4'd7, 1'b0, 64'h9, 64'h0);
        checks++;
        if ({wr_en, wr_addr, wr_data, wb_done, bad_icode, in_ready} !== {1'b1, 4'd3, 64'h25, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL opq: got en=%b addr=%h data=%h done=%b bad=%b rdy=%b required 1/3/25/1/0/1",
                     wr_en, wr_addr, wr_data, wb_done, bad_icode, in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({wr_en, wr_addr, wr_data, wb_done} !== {1'b1, 4'd7, 64'h9, 1'b1}) begin
            failures++;
            $display("FAIL irmovq_b2b: got en=%b addr=%h data=%h done=%b required 1/7/9/1", wr_en, wr_addr, wr_data, wb_done);
        end
        tick();
        checks++;
        if ({wr_en, wb_done, bad_icode} !== 3'b000) begin
            failures++; $display("FAIL idle_after_opq: got en=%b done=%b bad=%b required 000", wr_en, wb_done, bad_icode);
        end
    endtask

    task automatic test_popq(input logic [3:0] a, input logic [DW-1:0] e, input logic [DW-1:0] m);
        req(4'hB, a, 4'hF, 1'b0, e, m);
        tick();
        // held request during the second write cycle must wait
        req(4'h6, 4'hF, 4'd1, 1'b0, 64'h77, 64'h0);
        checks++;
        if ({wr_en, wr_addr, wr_data, wb_done, in_ready} !== {1'b1, 4'd4, e, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL popq_first: got en=%b addr=%h data=%h done=%b rdy=%b required 1/4/%h/0/0",
                     wr_en, wr_addr, wr_data, wb_done, in_ready, e);
        end
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, wb_done, in_ready} !== {1'b1, a, m, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL popq_second: got en=%b addr=%h data=%h done=%b rdy=%b required 1/%h/%h/1/1",
                     wr_en, wr_addr, wr_data, wb_done, in_ready, a, m);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({wr_en, wr_addr, wr_data, wb_done} !== {1'b1, 4'd1, 64'h77, 1'b1}) begin
            failures++;
            $display("FAIL popq_held_req: got en=%b addr=%h data=%h done=%b required 1/1/77/1", wr_en, wr_addr, wr_data, wb_done);
        end
        tick();
    endtask

    task automatic test_cmov();
        req(4'h2, 4'hF, 4'd5, 1'b0, 64'h7, 64'h0);
        tick();
        req(4'h2, 4'hF, 4'd5, 1'b1, 64'h7, 64'h0);
        checks++;
        if ({wr_en, wb_done, bad_icode} !== 3'b010) begin
            failures++; $display("FAIL cmov_cnd0: got en=%b done=%b bad=%b required 010", wr_en, wb_done, bad_icode);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({wr_en, wr_addr, wr_data, wb_done} !== {1'b1, 4'd5, 64'h7, 1'b1}) begin
            failures++;
            $display("FAIL cmov_cnd1: got en=%b addr=%h data=%h done=%b required 1/5/7/1", wr_en, wr_addr, wr_data, wb_done);
        end
        tick();
    endtask

    task automatic test_no_write();
        logic [3:0] ics [6] = '{4'h4, 4'h1, 4'h0, 4'h7, 4'hC, 4'hF};
        foreach (ics[i]) begin
            req(ics[i], 4'd2, 4'd3, 1'b1, 64'h1234, 64'h5678);
            tick();
            checks++;
            if ({wr_en, wb_done, bad_icode} !== {1'b0, 1'b1, ics[i] > 4'hB}) begin
                failures++;
                $display("FAIL no_write_icode_%h: got en=%b done=%b bad=%b required 0/1/%b",
                         ics[i], wr_en, wb_done, bad_icode, ics[i] > 4'hB);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_popq();
        req(4'hB, 4'd2, 4'hF, 1'b0, 64'h28, 64'hDEAD);
        tick();
        rst = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL midpop_ready: got %b required 0", in_ready);
        end
        tick();
        checks++;
        if ({wr_en, wr_addr, wr_data, wb_done, bad_icode} !== {1'b0, 4'hF, 64'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midpop_reset_outputs: got en=%b addr=%h data=%h done=%b bad=%b required 0/f/0/0/0",
                     wr_en, wr_addr, wr_data, wb_done, bad_icode);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({wr_en, wb_done, in_ready} !== 3'b001) begin
            failures++; $display("FAIL midpop_dropped: got en=%b done=%b rdy=%b required 001", wr_en, wb_done, in_ready);
        end
    endtask

    task automatic test_random();
        exp_t x;
        logic acc, exp_rdy;
        exp_q.delete();
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            icode    = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom);
            rA       = 4'($urandom);
            rB       = 4'($urandom);
            cnd      = 1'($urandom);
            valE     = {$urandom, $urandom};
            valM     = {$urandom, $urandom};
            exp_rdy  = (exp_q.size() == 0);
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++; $display("FAIL rand_ready[%0d]: got %b required %b", i, in_ready, exp_rdy);
            end
            acc = in_valid && exp_rdy;
            tick();
            if (acc) model(icode, rA, rB, cnd, valE, valM);
            if (exp_q.size() != 0) x = exp_q.pop_front();
            else x = '{en: 1'b0, addr: 4'hF, data: '0, done: 1'b0, bad: 1'b0};
            checks++;
            if ({wr_en, wb_done, bad_icode} !== {x.en, x.done, x.bad} ||
                (x.en && {wr_addr, wr_data} !== {x.addr, x.data})) begin
                failures++;
                $display("FAIL rand_out[%0d]: got en=%b addr=%h data=%h done=%b bad=%b required %b/%h/%h/%b/%b",
                         i, wr_en, wr_addr, wr_data, wb_done, bad_icode, x.en, x.addr, x.data, x.done, x.bad);
            end
        end
        in_valid = 1'b0;
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; icode = '0; rA = '0; rB = '0; cnd = 1'b0; valE = '0; valM = '0;
        test_reset();
        test_opq_back_to_back();
        test_popq(4'd2, 64'h28, 64'hDEAD);
        test_popq(4'd4, 64'h30, 64'h55);
        test_cmov();
        test_no_write();
        test_reset_mid_popq();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
